// File: rtl/onehot_key_capture_pkg.sv
// Shared definitions for the push-button front end and encoder-side checkers.
// Holds the key-capture FSM state encoding and one-hot legality helpers.
package onehot_key_capture_pkg;

    localparam int unsigned KEY_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } key_state_e;

    function automatic int unsigned key_popcount(input logic [KEY_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // True only for the four codes the downstream encoder may legally see.
    function automatic logic onehot_legal(input logic [KEY_W-1:0] v);
        return (key_popcount(v) == 1);
    endfunction

endpackage

// File: rtl/onehot_key_capture_debounce_vec.sv
// Two-flop synchroniser plus a single shared debounce counter for a button vector.
// The whole vector must be unchanged for DEBOUNCE_CYCLES clocks before it becomes stable.
module debounce_vec #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] stable
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_candidate;
    logic [WIDTH-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
            r_s  <= '0;
        end else begin
            r_s1 <= btn;
            r_s  <= r_s1;
        end
    end

    // Any bit change restarts the count; the counter saturates once the vector is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_candidate <= '0;
            r_stable    <= '0;
            r_cnt       <= '0;
        end else if (r_s != r_candidate) begin
            r_candidate <= r_s;
            r_cnt       <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_stable    <= r_candidate;
        end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/onehot_key_capture.sv
// Turns four raw push-buttons into a registered one-hot request for the 4-to-2 encoder.
// Only single-button presses are accepted; multi-button presses raise multi_err instead.
module onehot_key_capture
    import onehot_key_capture_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] btn,
    output logic [KEY_W-1:0] onehot,
    output logic             valid,
    output logic             code_valid,
    output logic             multi_err
);

    logic [KEY_W-1:0] w_stable;

    key_state_e       r_state;
    key_state_e       w_state_nxt;
    logic [KEY_W-1:0] r_onehot;
    logic [KEY_W-1:0] w_onehot_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_code_valid;
    logic             w_code_valid_nxt;
    logic             r_multi_err;
    logic             w_multi_err_nxt;

    debounce_vec #(
        .WIDTH           (KEY_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn),
        .stable (w_stable)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_onehot     <= '0;
            r_valid      <= 1'b0;
            r_code_valid <= 1'b0;
            r_multi_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_onehot     <= w_onehot_nxt;
            r_valid      <= w_valid_nxt;
            r_code_valid <= w_code_valid_nxt;
            r_multi_err  <= w_multi_err_nxt;
        end
    end

    // HELD swallows every change until all buttons are released, so pulses only leave IDLE.
    always_comb begin
        w_state_nxt      = r_state;
        w_onehot_nxt     = r_onehot;
        w_valid_nxt      = 1'b0;
        w_code_valid_nxt = r_code_valid;
        w_multi_err_nxt  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_stable != '0) begin
                    w_state_nxt = ST_HELD;
                    if (onehot_legal(w_stable)) begin
                        w_onehot_nxt     = w_stable;
                        w_valid_nxt      = 1'b1;
                        w_code_valid_nxt = 1'b1;
                    end else begin
                        w_multi_err_nxt  = 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (w_stable == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign onehot     = r_onehot;
    assign valid      = r_valid;
    assign code_valid = r_code_valid;
    assign multi_err  = r_multi_err;

endmodule

// File: tb/tb_onehot_key_capture.sv
// Directed bench for onehot_key_capture with DEBOUNCE_CYCLES = 4 (press-to-pulse latency 8).
module tb_onehot_key_capture;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] onehot;
    logic       valid;
    logic       code_valid;
    logic       multi_err;

    int unsigned n_checks;
    int unsigned n_fail;

    onehot_key_capture #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .onehot     (onehot),
        .valid      (valid),
        .code_valid (code_valid),
        .multi_err  (multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance n clocks checking pulses each cycle; a pulse is expected only on the given tick (0 = none).
    task automatic watch(input string tag, input int n, input int valid_at, input int multi_at);
        for (int i = 1; i <= n; i++) begin
            tick();
            chk({tag, " valid"}, {3'b000, valid}, {3'b000, (i == valid_at)});
            chk({tag, " multi_err"}, {3'b000, multi_err}, {3'b000, (i == multi_at)});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        btn      = 4'b0000;

        // 1. Reset
        tick(); tick(); tick();
        chk("reset onehot", onehot, 4'b0000);
        chk("reset valid", {3'b000, valid}, 4'b0000);
        chk("reset code_valid", {3'b000, code_valid}, 4'b0000);
        chk("reset multi_err", {3'b000, multi_err}, 4'b0000);
        rst = 1'b0;
        watch("idle", 4, 0, 0);
        chk("idle code_valid", {3'b000, code_valid}, 4'b0000);

        // 2. Clean press and release
        btn = 4'b0100;
        watch("press pre", 7, 0, 0);
        chk("press code_valid early", {3'b000, code_valid}, 4'b0000);
        watch("press", 13, 1, 0);
        chk("press onehot", onehot, 4'b0100);
        chk("press code_valid", {3'b000, code_valid}, 4'b0001);
        btn = 4'b0000;
        watch("release", 12, 0, 0);
        chk("release onehot", onehot, 4'b0100);
        chk("release code_valid", {3'b000, code_valid}, 4'b0001);

        // 3. Bounce then steady press
        btn = 4'b0010;
        watch("bounce hi", 3, 0, 0);
        btn = 4'b0000;
        watch("bounce lo", 2, 0, 0);
        btn = 4'b0010;
        watch("bounce final", 16, 8, 0);
        chk("bounce onehot", onehot, 4'b0010);
        btn = 4'b0000;
        watch("bounce release", 10, 0, 0);

        // 4. Multi-press, then legal press
        btn = 4'b1010;
        watch("multi", 16, 0, 8);
        chk("multi onehot", onehot, 4'b0010);
        chk("multi code_valid", {3'b000, code_valid}, 4'b0001);
        btn = 4'b0000;
        watch("multi release", 10, 0, 0);
        btn = 4'b1000;
        watch("after multi", 12, 8, 0);
        chk("after multi onehot", onehot, 4'b1000);
        btn = 4'b0000;
        watch("after multi release", 10, 0, 0);

        // 5. Add a button while held
        btn = 4'b0001;
        watch("add first", 12, 8, 0);
        chk("add first onehot", onehot, 4'b0001);
        btn = 4'b1001;
        watch("add second", 12, 0, 0);
        btn = 4'b0000;
        watch("add release", 12, 0, 0);
        chk("add onehot", onehot, 4'b0001);

        // 6. Reset while a button is held
        btn = 4'b0100;
        watch("hold", 12, 8, 0);
        chk("hold onehot", onehot, 4'b0100);
        rst = 1'b1;
        tick();
        chk("midrst onehot", onehot, 4'b0000);
        chk("midrst code_valid", {3'b000, code_valid}, 4'b0000);
        chk("midrst valid", {3'b000, valid}, 4'b0000);
        rst = 1'b0;
        watch("post rst", 12, 8, 0);
        chk("post rst onehot", onehot, 4'b0100);
        chk("post rst code_valid", {3'b000, code_valid}, 4'b0001);
        btn = 4'b0000;
        watch("final release", 10, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
